// File: rtl/crossbar_noc_pkg.sv
// Shared definitions for the APB crossbar NoC: bus geometry, target-port
// state encoding and initiator identifiers.
package crossbar_noc_pkg;

  localparam int NUM_INIT = 3;
  localparam int ADDR_W   = 60;  // {28-bit high, 32-bit low}
  localparam int DATA_W   = 32;

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    SETUP  = 2'b01,
    ACCESS = 2'b10,
    DONE   = 2'b11
  } port_state_e;

  localparam logic [1:0] INIT_ID_0 = 2'b00;
  localparam logic [1:0] INIT_ID_1 = 2'b01;
  localparam logic [1:0] INIT_ID_2 = 2'b10;

endpackage

// File: rtl/apb_target_port_if.sv
// Bundle of the initiator-side request/response lines and the APB lines of
// one target port. The "master" view is the target port itself (it masters
// the APB slave); the "slave" view is the fabric plus the attached component.
interface apb_target_port_if;
  import crossbar_noc_pkg::*;

  // Request side, one lane per initiator
  logic [NUM_INIT-1:0]             req_valid;
  logic [NUM_INIT-1:0]             req_write;
  logic [NUM_INIT-1:0][ADDR_W-1:0] req_addr;
  logic [NUM_INIT-1:0][DATA_W-1:0] req_wdata;

  // Completion side, shared by all initiators, qualified by done
  logic [NUM_INIT-1:0]             done;
  logic [DATA_W-1:0]               rsp_rdata;
  logic                            rsp_err;

  // APB3 towards the component
  logic                            psel;
  logic                            penable;
  logic                            pwrite;
  logic [ADDR_W-1:0]               paddr;
  logic [DATA_W-1:0]               pwdata;
  logic [DATA_W-1:0]               prdata;
  logic                            pready;
  logic                            pslverr;

  modport master (
    input  req_valid, req_write, req_addr, req_wdata,
    input  prdata, pready, pslverr,
    output done, rsp_rdata, rsp_err,
    output psel, penable, pwrite, paddr, pwdata
  );

  modport slave (
    output req_valid, req_write, req_addr, req_wdata,
    output prdata, pready, pslverr,
    input  done, rsp_rdata, rsp_err,
    input  psel, penable, pwrite, paddr, pwdata
  );

endinterface

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: grants the first asserted request at or
// after the priority pointer, wrapping around. Shared by all target ports.
module rr_arbiter #(
  parameter int NUM_INIT = 3,
  parameter int PTR_W    = 2
) (
  input  logic [NUM_INIT-1:0] req,
  input  logic [PTR_W-1:0]    ptr,
  output logic [NUM_INIT-1:0] grant,
  output logic                valid
);
  import crossbar_noc_pkg::*;

  int   dist_s;
  int   best_dist_s;
  int   best_idx_s;
  logic hit_s;

  // Pick the requester with the smallest rotated distance from the pointer
  always_comb begin
    dist_s      = 0;
    hit_s       = 1'b0;
    best_dist_s = NUM_INIT;
    best_idx_s  = 0;
    valid       = |req;
    grant       = {NUM_INIT{1'b0}};
    for (int j = 0; j < NUM_INIT; j++) begin
      dist_s      = (j + NUM_INIT - int'(ptr)) % NUM_INIT;
      hit_s       = req[j] && (dist_s < best_dist_s);
      best_dist_s = hit_s ? dist_s : best_dist_s;
      best_idx_s  = hit_s ? j : best_idx_s;
    end
    for (int j = 0; j < NUM_INIT; j++) begin
      grant[j] = valid && (best_idx_s == j);
    end
  end

endmodule

// File: rtl/apb_target_port.sv
// Target-side port of the APB crossbar NoC: arbitrates the initiator
// requests round-robin and runs each winner as one APB3 SETUP/ACCESS
// transfer, returning read data and error status as a one-cycle done pulse.
module apb_target_port #(
  parameter int NUM_INIT = crossbar_noc_pkg::NUM_INIT,
  parameter int ADDR_W   = crossbar_noc_pkg::ADDR_W,
  parameter int DATA_W   = crossbar_noc_pkg::DATA_W,
  parameter int TIMEOUT  = 16
) (
  input  logic             pclk,
  input  logic             preset_n,
  apb_target_port_if.master bus
);
  import crossbar_noc_pkg::*;

  localparam int PTR_W = (NUM_INIT > 1) ? $clog2(NUM_INIT) : 1;
  localparam int CNT_W = $clog2(TIMEOUT + 1);
  localparam logic [NUM_INIT-1:0] ONE_HOT_0 = {{(NUM_INIT-1){1'b0}}, 1'b1};
  localparam logic [PTR_W-1:0]    LAST_IDX  = PTR_W'(NUM_INIT - 1);

  port_state_e         state_r;
  logic [PTR_W-1:0]    ptr_r;
  logic [PTR_W-1:0]    winner_r;
  logic [CNT_W-1:0]    wait_cnt_r;

  logic [NUM_INIT-1:0] done_r;
  logic [DATA_W-1:0]   rsp_rdata_r;
  logic                rsp_err_r;
  logic                psel_r;
  logic                penable_r;
  logic                pwrite_r;
  logic [ADDR_W-1:0]   paddr_r;
  logic [DATA_W-1:0]   pwdata_r;

  logic [NUM_INIT-1:0] grant_s;
  logic                grant_valid_s;
  logic [PTR_W-1:0]    grant_idx_s;
  logic                access_end_s;

  rr_arbiter #(
    .NUM_INIT (NUM_INIT),
    .PTR_W    (PTR_W)
  ) u_arb (
    .req   (bus.req_valid),
    .ptr   (ptr_r),
    .grant (grant_s),
    .valid (grant_valid_s)
  );

  // Encode the one-hot grant into the winner index
  always_comb begin
    grant_idx_s = {PTR_W{1'b0}};
    for (int j = 0; j < NUM_INIT; j++) begin
      grant_idx_s = grant_s[j] ? PTR_W'(j) : grant_idx_s;
    end
  end

  // ACCESS ends on pready or on the last allowed wait cycle
  always_comb begin
    access_end_s = bus.pready || (wait_cnt_r == CNT_W'(TIMEOUT - 1));
  end

  // Transfer FSM with all outputs registered; the payload lives in the APB
  // output registers, which are zero outside SETUP/ACCESS
  always_ff @(posedge pclk or negedge preset_n) begin
    if (!preset_n) begin
      state_r     <= IDLE;
      ptr_r       <= {PTR_W{1'b0}};
      winner_r    <= {PTR_W{1'b0}};
      wait_cnt_r  <= {CNT_W{1'b0}};
      done_r      <= {NUM_INIT{1'b0}};
      rsp_rdata_r <= {DATA_W{1'b0}};
      rsp_err_r   <= 1'b0;
      psel_r      <= 1'b0;
      penable_r   <= 1'b0;
      pwrite_r    <= 1'b0;
      paddr_r     <= {ADDR_W{1'b0}};
      pwdata_r    <= {DATA_W{1'b0}};
    end else begin
      case (state_r)
        IDLE: begin
          done_r     <= {NUM_INIT{1'b0}};
          wait_cnt_r <= {CNT_W{1'b0}};
          if (grant_valid_s) begin
            winner_r <= grant_idx_s;
            psel_r   <= 1'b1;
            penable_r <= 1'b0;
            pwrite_r <= bus.req_write[grant_idx_s];
            paddr_r  <= bus.req_addr[grant_idx_s];
            pwdata_r <= bus.req_wdata[grant_idx_s];
            state_r  <= SETUP;
          end else begin
            state_r  <= IDLE;
          end
        end
        SETUP: begin
          penable_r  <= 1'b1;
          wait_cnt_r <= {CNT_W{1'b0}};
          state_r    <= ACCESS;
        end
        ACCESS: begin
          if (access_end_s) begin
            psel_r     <= 1'b0;
            penable_r  <= 1'b0;
            pwrite_r   <= 1'b0;
            paddr_r    <= {ADDR_W{1'b0}};
            pwdata_r   <= {DATA_W{1'b0}};
            wait_cnt_r <= {CNT_W{1'b0}};
            done_r     <= ONE_HOT_0 << winner_r;
            state_r    <= DONE;
            if (bus.pready) begin
              rsp_rdata_r <= pwrite_r ? {DATA_W{1'b0}} : bus.prdata;
              rsp_err_r   <= bus.pslverr;
            end else begin
              rsp_rdata_r <= {DATA_W{1'b0}};
              rsp_err_r   <= 1'b1;
            end
          end else begin
            wait_cnt_r <= wait_cnt_r + CNT_W'(1);
          end
        end
        DONE: begin
          done_r      <= {NUM_INIT{1'b0}};
          rsp_rdata_r <= {DATA_W{1'b0}};
          rsp_err_r   <= 1'b0;
          ptr_r       <= (winner_r == LAST_IDX) ? {PTR_W{1'b0}} : winner_r + PTR_W'(1);
          state_r     <= IDLE;
        end
        default: begin
          state_r     <= IDLE;
          wait_cnt_r  <= {CNT_W{1'b0}};
          done_r      <= {NUM_INIT{1'b0}};
          rsp_rdata_r <= {DATA_W{1'b0}};
          rsp_err_r   <= 1'b0;
          psel_r      <= 1'b0;
          penable_r   <= 1'b0;
          pwrite_r    <= 1'b0;
          paddr_r     <= {ADDR_W{1'b0}};
          pwdata_r    <= {DATA_W{1'b0}};
        end
      endcase
    end
  end

  assign bus.done      = done_r;
  assign bus.rsp_rdata = rsp_rdata_r;
  assign bus.rsp_err   = rsp_err_r;
  assign bus.psel      = psel_r;
  assign bus.penable   = penable_r;
  assign bus.pwrite    = pwrite_r;
  assign bus.paddr     = paddr_r;
  assign bus.pwdata    = pwdata_r;

endmodule

// File: tb/tb_apb_target_port.sv
// Self-checking bench for apb_target_port: scoreboard of expected done pulses
// plus a small APB slave model with configurable wait states and errors.
module tb_apb_target_port;
  import crossbar_noc_pkg::*;

  typedef struct {
    int          id;
    logic [31:0] rdata;
    logic        err;
    int          cyc;
  } exp_t;

  logic pclk;
  logic preset_n;

  apb_target_port_if bus ();

  apb_target_port #(
    .NUM_INIT (3),
    .ADDR_W   (60),
    .DATA_W   (32),
    .TIMEOUT  (16)
  ) dut (
    .pclk     (pclk),
    .preset_n (preset_n),
    .bus      (bus)
  );

  int          checks   = 0;
  int          failures = 0;
  int          cyc      = 0;
  exp_t        sb_q[$];

  int          wait_cfg = 0;
  logic        slv_hang = 1'b0;
  logic        slv_err  = 1'b0;
  logic [31:0] rd_xor   = 32'h0;
  int          acc_cnt  = 0;

  initial pclk = 1'b0;
  always #5 pclk = ~pclk;

  // Edge counter used as the time base for expected done cycles
  always @(posedge pclk) cyc <= cyc + 1;

  // APB slave model: pready after wait_cfg ACCESS cycles unless hung
  always @(negedge pclk) begin
    if (bus.psel && bus.penable) acc_cnt = acc_cnt + 1;
    else acc_cnt = 0;
    bus.pready  = bus.psel && bus.penable && !slv_hang && (acc_cnt > wait_cfg);
    bus.pslverr = bus.pready && slv_err;
    bus.prdata  = bus.psel ? (bus.paddr[31:0] ^ rd_xor) : 32'h0;
  end

  task automatic sync();
    @(posedge pclk);
    #1;
  endtask

  task automatic at_cycle(input int t);
    do @(negedge pclk); while (cyc < t);
  endtask

  task automatic post_req(input int id, input logic wr, input logic [59:0] addr,
                          input logic [31:0] wd);
    bus.req_write[id] = wr;
    bus.req_addr[id]  = addr;
    bus.req_wdata[id] = wd;
    bus.req_valid[id] = 1'b1;
  endtask

  // Pop and compare one scoreboard entry per done pulse; completed initiators drop req_valid
  task automatic drain_scoreboard(input int budget);
    exp_t       e;
    logic [2:0] exp_done;
    int         n;
    n = 0;
    while (sb_q.size() != 0 && n < budget) begin
      @(negedge pclk);
      n++;
      if (bus.done != 3'b000) begin
        e = sb_q.pop_front();
        exp_done = 3'b001 << e.id;
        checks++;
        if (bus.done !== exp_done) begin
          failures++; $display("FAIL done_id got=%b exp=%b", bus.done, exp_done);
        end
        checks++;
        if (bus.rsp_rdata !== e.rdata) begin
          failures++; $display("FAIL rsp_rdata id=%0d got=%h exp=%h", e.id, bus.rsp_rdata, e.rdata);
        end
        checks++;
        if (bus.rsp_err !== e.err) begin
          failures++; $display("FAIL rsp_err id=%0d got=%b exp=%b", e.id, bus.rsp_err, e.err);
        end
        checks++;
        if (cyc != e.cyc) begin
          failures++; $display("FAIL done_cycle id=%0d got=%0d exp=%0d", e.id, cyc, e.cyc);
        end
        bus.req_valid[e.id] = 1'b0;
      end
    end
    checks++;
    if (sb_q.size() != 0) begin
      failures++; $display("FAIL drain_timeout pending=%0d exp=0", sb_q.size());
      sb_q.delete();
    end
    @(negedge pclk);
    checks++;
    if (bus.done !== 3'b000) begin
      failures++; $display("FAIL done_width got=%b exp=000", bus.done);
    end
  endtask

  task automatic test_reset();
    preset_n      = 1'b0;
    bus.req_valid = 3'b000;
    bus.req_write = 3'b000;
    bus.req_addr  = '{default: 60'h0};
    bus.req_wdata = '{default: 32'h0};
    repeat (3) @(posedge pclk);
    #1;
    checks++;
    if ({bus.psel, bus.penable, bus.pwrite, bus.done, bus.rsp_err} !== 7'b0) begin
      failures++; $display("FAIL reset_ctrl got=%b exp=0",
                           {bus.psel, bus.penable, bus.pwrite, bus.done, bus.rsp_err});
    end
    checks++;
    if ({bus.paddr, bus.pwdata, bus.rsp_rdata} !== 124'h0) begin
      failures++; $display("FAIL reset_data got=%h exp=0", {bus.paddr, bus.pwdata, bus.rsp_rdata});
    end
    @(negedge pclk);
    preset_n = 1'b1;
    sync();
    sync();
    checks++;
    if (bus.psel !== 1'b0) begin
      failures++; $display("FAIL idle_psel got=%b exp=0", bus.psel);
    end
  endtask

  task automatic test_round_robin();
    int n;
    rd_xor = 32'hA5A5_A5A5;
    sync();
    n = cyc + 1;
    post_req(int'(INIT_ID_0), 1'b0, 60'h111_0000_0000_1000, 32'h0);
    post_req(int'(INIT_ID_1), 1'b0, 60'h222_0000_0000_2000, 32'h0);
    post_req(int'(INIT_ID_2), 1'b0, 60'h333_0000_0000_3000, 32'h0);
    sb_q.push_back('{id: 0, rdata: 32'h0000_1000 ^ 32'hA5A5_A5A5, err: 1'b0, cyc: n + 2});
    sb_q.push_back('{id: 1, rdata: 32'h0000_2000 ^ 32'hA5A5_A5A5, err: 1'b0, cyc: n + 6});
    sb_q.push_back('{id: 2, rdata: 32'h0000_3000 ^ 32'hA5A5_A5A5, err: 1'b0, cyc: n + 10});
    drain_scoreboard(64);
    sync();
    n = cyc + 1;
    post_req(int'(INIT_ID_2), 1'b1, 60'h333_0000_0000_3300, 32'h3333_3333);
    post_req(int'(INIT_ID_0), 1'b1, 60'h111_0000_0000_1100, 32'h1111_1111);
    sb_q.push_back('{id: 0, rdata: 32'h0, err: 1'b0, cyc: n + 2});
    sb_q.push_back('{id: 2, rdata: 32'h0, err: 1'b0, cyc: n + 6});
    drain_scoreboard(64);
  endtask

  task automatic test_single_write();
    int n;
    sync();
    n = cyc + 1;
    post_req(int'(INIT_ID_1), 1'b1, 60'h0AB_CDEF_0123_4567, 32'hDEAD_BEEF);
    sb_q.push_back('{id: 1, rdata: 32'h0, err: 1'b0, cyc: n + 2});
    at_cycle(n);
    checks++;
    if ({bus.psel, bus.penable} !== 2'b10) begin
      failures++; $display("FAIL setup_phase got=%b exp=10", {bus.psel, bus.penable});
    end
    checks++;
    if (bus.paddr !== 60'h0AB_CDEF_0123_4567) begin
      failures++; $display("FAIL setup_paddr got=%h exp=%h", bus.paddr, 60'h0AB_CDEF_0123_4567);
    end
    checks++;
    if ({bus.pwrite, bus.pwdata} !== {1'b1, 32'hDEAD_BEEF}) begin
      failures++; $display("FAIL setup_wdata got=%b/%h exp=1/deadbeef", bus.pwrite, bus.pwdata);
    end
    at_cycle(n + 1);
    checks++;
    if ({bus.psel, bus.penable} !== 2'b11) begin
      failures++; $display("FAIL access_phase got=%b exp=11", {bus.psel, bus.penable});
    end
    drain_scoreboard(32);
    checks++;
    if ({bus.psel, bus.pwrite, bus.paddr, bus.pwdata} !== 94'h0) begin
      failures++; $display("FAIL idle_payload got=%h exp=0", {bus.psel, bus.pwrite, bus.paddr, bus.pwdata});
    end
  endtask

  task automatic test_wait_read();
    int n;
    wait_cfg = 3;
    rd_xor   = 32'h1234_5678;
    sync();
    n = cyc + 1;
    post_req(int'(INIT_ID_0), 1'b0, 60'h00F_0000_0000_0000, 32'hFFFF_FFFF);
    sb_q.push_back('{id: 0, rdata: 32'h1234_5678, err: 1'b0, cyc: n + 5});
    at_cycle(n + 3);
    checks++;
    if ({bus.psel, bus.penable, bus.paddr} !== {2'b11, 60'h00F_0000_0000_0000}) begin
      failures++; $display("FAIL wait_hold got=%b/%h exp=11/00f000000000000",
                           {bus.psel, bus.penable}, bus.paddr);
    end
    drain_scoreboard(32);
    wait_cfg = 0;
  endtask

  task automatic test_timeout();
    int n;
    rd_xor   = 32'hA5A5_A5A5;
    slv_hang = 1'b1;
    sync();
    n = cyc + 1;
    post_req(int'(INIT_ID_1), 1'b0, 60'h0C0_0000_0000_00C0, 32'h0);
    sb_q.push_back('{id: 1, rdata: 32'h0, err: 1'b1, cyc: n + 17});
    at_cycle(n + 16);
    checks++;
    if ({bus.psel, bus.penable, bus.done} !== 5'b11000) begin
      failures++; $display("FAIL timeout_wait got=%b exp=11000", {bus.psel, bus.penable, bus.done});
    end
    drain_scoreboard(40);
    slv_hang = 1'b0;
    sync();
    n = cyc + 1;
    post_req(int'(INIT_ID_1), 1'b1, 60'h0C0_0000_0000_00C4, 32'h0BAD_F00D);
    sb_q.push_back('{id: 1, rdata: 32'h0, err: 1'b0, cyc: n + 2});
    drain_scoreboard(32);
  endtask

  task automatic test_slverr();
    int n;
    slv_err = 1'b1;
    sync();
    n = cyc + 1;
    post_req(int'(INIT_ID_2), 1'b1, 60'h0E0_0000_0000_0E00, 32'hCAFE_0001);
    sb_q.push_back('{id: 2, rdata: 32'h0, err: 1'b1, cyc: n + 2});
    drain_scoreboard(32);
    slv_err = 1'b0;
  endtask

  task automatic test_reset_mid();
    int n;
    slv_hang = 1'b1;
    sync();
    n = cyc + 1;
    post_req(int'(INIT_ID_0), 1'b1, 60'h0F0_1234_0000_0F00, 32'h5555_AAAA);
    at_cycle(n + 3);
    checks++;
    if ({bus.psel, bus.penable, bus.pwrite} !== 3'b111) begin
      failures++; $display("FAIL pre_reset_access got=%b exp=111", {bus.psel, bus.penable, bus.pwrite});
    end
    #2;
    preset_n = 1'b0;
    bus.req_valid[0] = 1'b0;
    #1;
    checks++;
    if ({bus.psel, bus.penable, bus.pwrite, bus.done, bus.rsp_err} !== 7'b0) begin
      failures++; $display("FAIL async_reset_ctrl got=%b exp=0",
                           {bus.psel, bus.penable, bus.pwrite, bus.done, bus.rsp_err});
    end
    checks++;
    if ({bus.paddr, bus.pwdata, bus.rsp_rdata} !== 124'h0) begin
      failures++; $display("FAIL async_reset_data got=%h exp=0", {bus.paddr, bus.pwdata, bus.rsp_rdata});
    end
    post_req(int'(INIT_ID_2), 1'b0, 60'h0F0_0000_0000_2F00, 32'h0);
    slv_hang = 1'b0;
    sync();
    checks++;
    if ({bus.psel, bus.done} !== 4'b0) begin
      failures++; $display("FAIL reset_hold got=%b exp=0", {bus.psel, bus.done});
    end
    @(negedge pclk);
    #1;
    preset_n = 1'b1;
    n = cyc + 1;
    sb_q.push_back('{id: 2, rdata: 32'h0000_2F00 ^ 32'hA5A5_A5A5, err: 1'b0, cyc: n + 2});
    drain_scoreboard(32);
  endtask

  initial begin
    test_reset();
    test_round_robin();
    test_single_write();
    test_wait_read();
    test_timeout();
    test_slverr();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
